prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter CSUM_EN, default 1, meaning checksum byte is compared (1) or consumed and ignored (0).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port nreset  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port i_start  input  1  one-cycle request to begin a program load.
REQ-005 SHALL have port i_byte  input  8  incoming stream byte.
REQ-006 SHALL have port i_valid  input  1  i_byte is valid this cycle.
REQ-007 SHALL have port o_ready  output  1  loader accepts a byte this cycle.
REQ-008 SHALL have port o_rom_we  output  1  one-cycle write strobe to the CPU instruction ROM.
REQ-009 SHALL have port o_rom_addr  output  8  ROM write address.
REQ-010 SHALL have port o_rom_data  output  15  ROM write data (instruction word).
REQ-011 SHALL have port o_cpu_nreset  output  1  active-low reset to the CPU; high only after a good load.
REQ-012 SHALL have ports o_busy, o_done, o_err  output  1 each  load in progress / load succeeded / load failed.

Function
REQ-013 Byte accepted only on a rising edge with i_valid=1 and o_ready=1; no other byte affects state.
REQ-014 Stream format: LEN byte N, then N word pairs (HI, LO), then CSUM byte; N=0 means 256 words.
REQ-015 States: IDLE, LEN, HI, LO, CSUM, DONE, ERR; o_ready=1 exactly in LEN, HI, LO, CSUM.
REQ-016 IDLE/DONE/ERR + i_start -> LEN next cycle; word counter, address and running sum cleared; o_done=0, o_err=0, o_cpu_nreset=0.
REQ-017 i_start ignored in LEN, HI, LO, CSUM.
REQ-018 LEN: accepted byte stored as N, added to sum, -> HI.
REQ-019 HI: accepted byte with bit7=1 -> ERR immediately, no write; else bits6:0 held as data[14:8], added to sum, -> LO.
REQ-020 LO: accepted byte gives data[7:0], added to sum; next cycle o_rom_we=1 for exactly one cycle with o_rom_addr = current address, o_rom_data = {HI[6:0], LO}.
REQ-021 After each write address increments by 1 (8-bit, 255 wraps to 0); after the Nth word -> CSUM, else -> HI.
REQ-022 Latency: LO acceptance to o_rom_we = 1 cycle; a following HI may be accepted on the strobe cycle (back-to-back bytes, no stall).
REQ-023 Sum = 8-bit wrap-around sum of LEN and all HI/LO bytes.
REQ-024 CSUM: accepted byte == sum (or CSUM_EN=0) -> DONE; else -> ERR.
REQ-025 DONE: o_done=1, o_cpu_nreset=1 from the cycle after CSUM acceptance; held until i_start or nreset.
REQ-026 ERR: o_err=1, o_cpu_nreset=0; ROM words already written are not undone.
REQ-027 o_busy=1 exactly in LEN, HI, LO, CSUM.
REQ-028 o_rom_addr/o_rom_data hold last written values when o_rom_we=0.

Reset
REQ-029 nreset=0 at a clock edge SHALL force IDLE from any state, including mid-load, overriding i_start.
REQ-030 Reset values: o_ready=0, o_rom_we=0, o_rom_addr=0x00, o_rom_data=0x0000, o_cpu_nreset=0, o_busy=0, o_done=0, o_err=0; counters and sum 0.
REQ-031 A write strobe pending at the reset edge SHALL be cancelled.

Verification
REQ-032 Start, stream 02,40,01,01,02,46 with valid every cycle -> writes addr0=0x4001, addr1=0x0102; o_done=1, o_cpu_nreset=1.
REQ-033 Same stream with CSUM 0x47 -> two writes, then o_err=1, o_cpu_nreset=0; with CSUM_EN=0 -> o_done=1.
REQ-034 Stream 01,80 -> o_err=1 the cycle after 0x80 accepted, no o_rom_we, o_ready=0.
REQ-035 Random i_valid gaps on REQ-032 stream -> identical writes and result; unaccepted bytes ignored.
REQ-036 N=0, 256 word pairs + correct CSUM -> 256 strobes, addresses 0..255 in order, o_done=1.
REQ-037 nreset pulse after third byte of REQ-032 stream -> all outputs at reset values; fresh i_start and full stream then succeeds.

Source files
------------

// File: rtl/prog_loader.sv
// Streams a length-prefixed program image into the CPU instruction ROM and
// releases the CPU from reset only after the whole image and checksum are good.
module prog_loader #(
  parameter bit CSUM_EN = 1'b1
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        i_start,
  input  logic [7:0]  i_byte,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_rom_we,
  output logic [7:0]  o_rom_addr,
  output logic [14:0] o_rom_data,
  output logic        o_cpu_nreset,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_HI,
    S_LO,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic [7:0]  r_len;
  logic [8:0]  r_wordCnt;
  logic [7:0]  r_addr;
  logic [7:0]  r_sum;
  logic [6:0]  r_hi;
  logic        r_romWe;
  logic [7:0]  r_romAddr;
  logic [14:0] r_romData;

  logic        w_accept;
  logic [8:0]  w_total;
  logic        w_lastWord;
  logic        w_csumOk;

  assign w_accept   = i_valid && o_ready;
  // A length byte of zero stands for a full 256-word image.
  assign w_total    = (r_len == 8'd0) ? 9'd256 : {1'b0, r_len};
  assign w_lastWord = ((r_wordCnt + 9'd1) == w_total);
  assign w_csumOk   = (CSUM_EN == 1'b0) || (i_byte == r_sum);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (i_start) w_nextState = S_LEN;
      end
      S_LEN: begin
        if (w_accept) w_nextState = S_HI;
      end
      S_HI: begin
        if (w_accept) w_nextState = i_byte[7] ? S_ERR : S_LO;
      end
      S_LO: begin
        if (w_accept) w_nextState = w_lastWord ? S_CSUM : S_HI;
      end
      S_CSUM: begin
        if (w_accept) w_nextState = w_csumOk ? S_DONE : S_ERR;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    o_ready      = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_err        = 1'b0;
    o_cpu_nreset = 1'b0;
    case (r_state)
      S_LEN, S_HI, S_LO, S_CSUM: begin
        o_ready = 1'b1;
        o_busy  = 1'b1;
      end
      S_DONE: begin
        o_done       = 1'b1;
        o_cpu_nreset = 1'b1;
      end
      S_ERR: begin
        o_err = 1'b1;
      end
      default: ;
    endcase
  end

  // The ROM strobe is registered off the LO byte, so a reset on that same
  // edge wins and the write never appears.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_len     <= 8'd0;
      r_wordCnt <= 9'd0;
      r_addr    <= 8'd0;
      r_sum     <= 8'd0;
      r_hi      <= 7'd0;
      r_romWe   <= 1'b0;
      r_romAddr <= 8'd0;
      r_romData <= 15'd0;
    end else begin
      r_romWe <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (i_start) begin
            r_len     <= 8'd0;
            r_wordCnt <= 9'd0;
            r_addr    <= 8'd0;
            r_sum     <= 8'd0;
          end
        end
        S_LEN: begin
          if (w_accept) begin
            r_len <= i_byte;
            r_sum <= r_sum + i_byte;
          end
        end
        S_HI: begin
          if (w_accept && !i_byte[7]) begin
            r_hi  <= i_byte[6:0];
            r_sum <= r_sum + i_byte;
          end
        end
        S_LO: begin
          if (w_accept) begin
            r_sum     <= r_sum + i_byte;
            r_romWe   <= 1'b1;
            r_romAddr <= r_addr;
            r_romData <= {r_hi, i_byte};
            r_addr    <= r_addr + 8'd1;
            r_wordCnt <= r_wordCnt + 9'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rom_we   = r_romWe;
  assign o_rom_addr = r_romAddr;
  assign o_rom_data = r_romData;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized checks of prog_loader against a stream-level model; two
// instances run in lockstep, one with checksum checking and one without.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        nreset;
  logic        i_start;
  logic [7:0]  i_byte;
  logic        i_valid;

  logic        aReady, aWe, aCpu, aBusy, aDone, aErr;
  logic [7:0]  aAddr;
  logic [14:0] aData;
  logic        bReady, bWe, bCpu, bBusy, bDone, bErr;
  logic [7:0]  bAddr;
  logic [14:0] bData;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [7:0]  stream[$];
  logic [22:0] expWr[$];
  logic [22:0] wrA[$];
  logic [22:0] wrB[$];
  int          nSend;
  int          expN;
  bit          expErrA;
  bit          expErrB;

  prog_loader #(.CSUM_EN(1'b1)) dutA (
    .clk(clk), .nreset(nreset), .i_start(i_start), .i_byte(i_byte), .i_valid(i_valid),
    .o_ready(aReady), .o_rom_we(aWe), .o_rom_addr(aAddr), .o_rom_data(aData),
    .o_cpu_nreset(aCpu), .o_busy(aBusy), .o_done(aDone), .o_err(aErr)
  );

  prog_loader #(.CSUM_EN(1'b0)) dutB (
    .clk(clk), .nreset(nreset), .i_start(i_start), .i_byte(i_byte), .i_valid(i_valid),
    .o_ready(bReady), .o_rom_we(bWe), .o_rom_addr(bAddr), .o_rom_data(bData),
    .o_cpu_nreset(bCpu), .o_busy(bBusy), .o_done(bDone), .o_err(bErr)
  );

  always #5 clk = ~clk;

  // Capture every ROM write of both instances as {addr, data}.
  always @(negedge clk) begin
    if (aWe) wrA.push_back({aAddr, aData});
    if (bWe) wrB.push_back({bAddr, bData});
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "-readyA"}, aReady, 0);
    checkOutput({tag, "-weA"}, aWe, 0);
    checkOutput({tag, "-addrA"}, aAddr, 0);
    checkOutput({tag, "-dataA"}, aData, 0);
    checkOutput({tag, "-cpuA"}, aCpu, 0);
    checkOutput({tag, "-busyA"}, aBusy, 0);
    checkOutput({tag, "-doneA"}, aDone, 0);
    checkOutput({tag, "-errA"}, aErr, 0);
    checkOutput({tag, "-busyB"}, bBusy, 0);
    checkOutput({tag, "-weB"}, bWe, 0);
  endtask

  task automatic pulseStart();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    i_valid = 1'b1;
    i_byte  = b;
    tick();
    i_valid = 1'b0;
  endtask

  // Builds a stream of n words; optionally one HI byte with bit7 set and/or a wrong checksum.
  task automatic genStream(input int n, input bit badHi, input bit badCsum);
    logic [7:0] sum;
    logic [7:0] b;
    int badPos;
    badPos = $urandom_range(n - 1);
    stream.delete();
    b = 8'(n);
    stream.push_back(b);
    sum = b;
    for (int k = 0; k < n; k++) begin
      b = {1'b0, 7'($urandom)};
      if (badHi && k == badPos) b[7] = 1'b1;
      stream.push_back(b);
      sum = sum + b;
      b = 8'($urandom);
      stream.push_back(b);
      sum = sum + b;
    end
    if (badCsum) sum = sum + 8'(1 + $urandom_range(254));
    stream.push_back(sum);
  endtask

  // Stream-level model: which bytes get consumed, which writes result, final verdicts.
  task automatic buildExpect();
    logic [7:0] sum;
    logic [7:0] hi;
    logic [7:0] lo;
    bit hiBad;
    expWr.delete();
    expN  = (stream[0] == 8'd0) ? 256 : int'(stream[0]);
    sum   = stream[0];
    nSend = 1;
    hiBad = 1'b0;
    for (int k = 0; k < expN; k++) begin
      hi = stream[1 + 2 * k];
      lo = stream[2 + 2 * k];
      nSend++;
      if (hi[7]) begin
        hiBad = 1'b1;
        break;
      end
      nSend++;
      sum = sum + hi + lo;
      expWr.push_back({8'(k), hi[6:0], lo});
    end
    if (!hiBad) nSend++;
    expErrB = hiBad;
    expErrA = hiBad || (stream[2 * expN + 1] != sum);
  endtask

  function automatic bit isLo(input int i);
    return (i >= 2) && (i % 2 == 0) && (i <= 2 * expN);
  endfunction

  task automatic checkWrites(input string tag);
    logic [22:0] last;
    checkOutput({tag, "-nWrA"}, wrA.size(), expWr.size());
    checkOutput({tag, "-nWrB"}, wrB.size(), expWr.size());
    for (int i = 0; i < expWr.size(); i++) begin
      if (i < wrA.size()) checkOutput({tag, "-wrA"}, wrA[i], expWr[i]);
      if (i < wrB.size()) checkOutput({tag, "-wrB"}, wrB[i], expWr[i]);
    end
    if (expWr.size() > 0) begin
      last = expWr[expWr.size() - 1];
      checkOutput({tag, "-holdA"}, {aAddr, aData}, last);
    end
  endtask

  // Runs the current stream with random i_valid gaps and optional i_start noise while busy.
  task automatic applyStimulus(input string tag, input int gapPct, input bit startNoise);
    buildExpect();
    pulseStart();
    wrA.delete();
    wrB.delete();
    checkOutput({tag, "-startBusy"}, aBusy, 1);
    checkOutput({tag, "-startCpu"}, aCpu, 0);
    checkOutput({tag, "-startDone"}, aDone | aErr, 0);
    for (int i = 0; i < nSend; i++) begin
      while ($urandom_range(99) < gapPct) begin
        i_valid = 1'b0;
        i_byte  = 8'($urandom);
        i_start = startNoise && ($urandom_range(3) == 0);
        tick();
        i_start = 1'b0;
      end
      checkOutput({tag, "-ready"}, aReady, 1);
      sendByte(stream[i]);
      checkOutput({tag, "-strobe"}, aWe, isLo(i));
    end
    checkOutput({tag, "-errA"}, aErr, expErrA);
    checkOutput({tag, "-doneA"}, aDone, !expErrA);
    checkOutput({tag, "-cpuA"}, aCpu, !expErrA);
    checkOutput({tag, "-errB"}, bErr, expErrB);
    checkOutput({tag, "-doneB"}, bDone, !expErrB);
    checkOutput({tag, "-readyEnd"}, aReady, 0);
    for (int i = 0; i < 3; i++) begin
      i_byte  = 8'($urandom);
      i_valid = $urandom_range(1);
      tick();
    end
    i_valid = 1'b0;
    checkOutput({tag, "-holdDoneA"}, aDone, !expErrA);
    checkOutput({tag, "-holdErrA"}, aErr, expErrA);
    checkWrites(tag);
  endtask

  initial begin
    nreset  = 1'b0;
    i_start = 1'b1;
    i_byte  = 8'h00;
    i_valid = 1'b0;
    tick();
    tick();
    i_start = 1'b0;
    checkResetValues("reset");
    nreset = 1'b1;
    tick();
    checkOutput("idleBusy", aBusy, 0);

    stream = {8'h02, 8'h40, 8'h01, 8'h01, 8'h02, 8'h46};
    applyStimulus("basic", 0, 0);

    stream = {8'h02, 8'h40, 8'h01, 8'h01, 8'h02, 8'h47};
    applyStimulus("badCsum", 0, 0);

    stream = {8'h01, 8'h80, 8'h00, 8'h00};
    applyStimulus("badHi", 0, 0);

    stream = {8'h02, 8'h40, 8'h01, 8'h01, 8'h02, 8'h46};
    applyStimulus("gaps", 50, 1);

    genStream(256, 1'b0, 1'b0);
    applyStimulus("full256", 10, 0);

    // Reset one cycle after the third byte: the first write has already happened.
    pulseStart();
    sendByte(8'h02);
    sendByte(8'h40);
    sendByte(8'h01);
    nreset  = 1'b0;
    i_start = 1'b1;
    tick();
    nreset  = 1'b1;
    i_start = 1'b0;
    checkResetValues("midReset");
    stream = {8'h02, 8'h40, 8'h01, 8'h01, 8'h02, 8'h46};
    applyStimulus("afterReset", 20, 0);

    // Reset on the same edge as a LO byte cancels its write.
    pulseStart();
    sendByte(8'h02);
    sendByte(8'h40);
    wrA.delete();
    i_valid = 1'b1;
    i_byte  = 8'h01;
    nreset  = 1'b0;
    tick();
    nreset  = 1'b1;
    i_valid = 1'b0;
    checkResetValues("cancelWe");
    tick();
    checkOutput("cancelWe-noWrite", wrA.size(), 0);

    for (int t = 0; t < 12; t++) begin
      genStream($urandom_range(1, 12), $urandom_range(3) == 0, $urandom_range(2) == 0);
      applyStimulus("random", 30, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
